// File: rtl/tl_phase_scheduler_if.sv
// Sensor inputs and lamp/debug outputs of the actuated phase scheduler.
// The master side drives the sensors; the slave side is the scheduler.
interface tl_phase_scheduler_if;
    logic       car_farm;
    logic       car_left;
    logic       HGS;
    logic       HGL;
    logic       HGR;
    logic       HY;
    logic       HR;
    logic       FG;
    logic       FY;
    logic       FR;
    logic [2:0] phase;
    logic       farm_pend;
    logic       left_pend;

    modport master (
        output car_farm, car_left,
        input  HGS, HGL, HGR, HY, HR, FG, FY, FR, phase, farm_pend, left_pend
    );

    modport slave (
        input  car_farm, car_left,
        output HGS, HGL, HGR, HY, HR, FG, FY, FR, phase, farm_pend, left_pend
    );
endinterface

// File: rtl/tl_phase_scheduler.sv
// Actuated highway/farm-road phase scheduler: latched requests, round-robin
// between left turn and farm road, timed green/yellow/clearance phases.
module tl_phase_scheduler #(
    parameter int T_MIN_GREEN = 8,
    parameter int T_LEFT      = 4,
    parameter int T_YEL       = 3,
    parameter int T_CLR       = 1,
    parameter int T_FARM_MIN  = 5,
    parameter int T_FARM_MAX  = 12,
    parameter int CW          = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    tl_phase_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        HWY_GO   = 3'd0,
        HWY_LEFT = 3'd1,
        HWY_YEL  = 3'd2,
        CLR1     = 3'd3,
        FARM_GO  = 3'd4,
        FARM_YEL = 3'd5,
        CLR2     = 3'd6
    } state_e;

    localparam logic [CW-1:0] MIN_GREEN_L = CW'(T_MIN_GREEN - 1);
    localparam logic [CW-1:0] LEFT_L      = CW'(T_LEFT - 1);
    localparam logic [CW-1:0] YEL_L       = CW'(T_YEL - 1);
    localparam logic [CW-1:0] CLR_L       = CW'(T_CLR - 1);
    localparam logic [CW-1:0] FARM_MIN_L  = CW'(T_FARM_MIN - 1);
    localparam logic [CW-1:0] FARM_MAX_L  = CW'(T_FARM_MAX - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            farm_pend_q, farm_pend_d;
    logic            left_pend_q, left_pend_d;
    logic            last_grant_q, last_grant_d;
    logic            enter_farm, enter_left;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HWY_GO: begin
                if (cnt_q >= MIN_GREEN_L && (farm_pend_q || left_pend_q)) begin
                    // Round-robin: left wins unless it was the last one served.
                    if (left_pend_q && (!farm_pend_q || last_grant_q))
                        state_d = HWY_LEFT;
                    else
                        state_d = HWY_YEL;
                end
            end
            HWY_LEFT: if (cnt_q == LEFT_L) state_d = farm_pend_q ? HWY_YEL : HWY_GO;
            HWY_YEL:  if (cnt_q == YEL_L)  state_d = CLR1;
            CLR1:     if (cnt_q == CLR_L)  state_d = FARM_GO;
            FARM_GO: begin
                if ((cnt_q >= FARM_MIN_L && !bus.car_farm) || cnt_q == FARM_MAX_L)
                    state_d = FARM_YEL;
            end
            FARM_YEL: if (cnt_q == YEL_L)  state_d = CLR2;
            CLR2:     if (cnt_q == CLR_L)  state_d = HWY_GO;
            default:  state_d = HWY_GO;
        endcase
    end

    assign enter_farm = (state_d == FARM_GO)  && (state_q != FARM_GO);
    assign enter_left = (state_d == HWY_LEFT) && (state_q != HWY_LEFT);

    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        farm_pend_d  = farm_pend_q | (bus.car_farm & (state_q != FARM_GO));
        left_pend_d  = left_pend_q | (bus.car_left & (state_q != HWY_LEFT));
        last_grant_d = last_grant_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == HWY_GO && cnt_q == MIN_GREEN_L)
            cnt_d = cnt_q;
        if (enter_farm) begin
            farm_pend_d  = 1'b0;
            last_grant_d = 1'b1;
        end
        if (enter_left) begin
            left_pend_d  = 1'b0;
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HWY_GO;
            cnt_q        <= '0;
            farm_pend_q  <= 1'b0;
            left_pend_q  <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            farm_pend_q  <= farm_pend_d;
            left_pend_q  <= left_pend_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Moore lamp decode, order {HGS,HGL,HGR,HY,HR,FG,FY,FR}.
    logic [7:0] lamps;
    always_comb begin
        lamps = 8'b0000_1001;
        unique case (state_q)
            HWY_GO:   lamps = 8'b1010_0001;
            HWY_LEFT: lamps = 8'b0110_0001;
            HWY_YEL:  lamps = 8'b0001_0001;
            CLR1:     lamps = 8'b0000_1001;
            FARM_GO:  lamps = 8'b0000_1100;
            FARM_YEL: lamps = 8'b0000_1010;
            CLR2:     lamps = 8'b0000_1001;
            default:  lamps = 8'b0000_1001;
        endcase
    end

    assign {bus.HGS, bus.HGL, bus.HGR, bus.HY, bus.HR, bus.FG, bus.FY, bus.FR} = lamps;
    assign bus.phase     = state_q;
    assign bus.farm_pend = farm_pend_q;
    assign bus.left_pend = left_pend_q;
endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Scoreboard bench for tl_phase_scheduler: directed scenarios plus random
// sensor traffic, checked against a duration-based phase model.
module tb_tl_phase_scheduler;
    localparam int T_MIN_GREEN = 8;
    localparam int T_LEFT      = 4;
    localparam int T_YEL       = 3;
    localparam int T_CLR       = 1;
    localparam int T_FARM_MIN  = 5;
    localparam int T_FARM_MAX  = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    tl_phase_scheduler_if bus ();

    tl_phase_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [12:0] exp_q[$];

    // Lamp pattern per phase, {HGS,HGL,HGR,HY,HR,FG,FY,FR}.
    logic [7:0] lamp_tbl [0:6] = '{8'b1010_0001, 8'b0110_0001, 8'b0001_0001,
                                   8'b0000_1001, 8'b0000_1100, 8'b0000_1010,
                                   8'b0000_1001};
    int dur [0:6] = '{0, T_LEFT, T_YEL, T_CLR, 0, T_YEL, T_CLR};

    int m_ph, m_t;
    bit m_fp, m_lp, m_lg;

    function automatic void model_reset();
        m_ph = 0; m_t = 0; m_fp = 0; m_lp = 0; m_lg = 0;
    endfunction

    // Advance one clock: phase ends once it has lasted its duration.
    function automatic void model_step(bit cf, bit cl);
        int  nx   = m_ph;
        int  age  = m_t + 1;
        bit  done = (dur[m_ph] != 0) && (age >= dur[m_ph]);
        case (m_ph)
            0: if (age >= T_MIN_GREEN && (m_fp || m_lp))
                   nx = (m_lp && (!m_fp || m_lg)) ? 1 : 2;
            1: if (done) nx = m_fp ? 2 : 0;
            4: if ((age >= T_FARM_MIN && !cf) || age >= T_FARM_MAX) nx = 5;
            6: if (done) nx = 0;
            default: if (done) nx = m_ph + 1;
        endcase
        m_fp = (m_fp || (cf && m_ph != 4)) && !(nx == 4 && m_ph != 4);
        m_lp = (m_lp || (cl && m_ph != 1)) && !(nx == 1 && m_ph != 1);
        if (nx == 1 && m_ph != 1) m_lg = 0;
        if (nx == 4 && m_ph != 4) m_lg = 1;
        m_t  = (nx != m_ph) ? 0 : age;
        m_ph = nx;
    endfunction

    function automatic logic [12:0] model_out();
        logic [2:0] p = 3'(m_ph);
        return {lamp_tbl[m_ph], p, m_fp, m_lp};
    endfunction

    function automatic logic [12:0] dut_out();
        return {bus.HGS, bus.HGL, bus.HGR, bus.HY, bus.HR, bus.FG, bus.FY, bus.FR,
                bus.phase, bus.farm_pend, bus.left_pend};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every post-edge DUT state against the scoreboard and invariants.
    initial begin
        logic [12:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_out();
                chk("scoreboard", int'(a), int'(e));
                chk("inv_hwy_one", int'(bus.HGS | bus.HGL) + int'(bus.HY) + int'(bus.HR), 1);
                chk("inv_farm_one", int'(bus.FG) + int'(bus.FY) + int'(bus.FR), 1);
                chk("inv_fg_hr", int'(bus.FG & ~bus.HR), 0);
            end
        end
    end

    // Called at a negedge: drive this cycle's sensors, predict the next state.
    task automatic cyc_drive(input bit cf, input bit cl);
        bus.car_farm = cf;
        bus.car_left = cl;
        model_step(cf, cl);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    // Asserted mid-cycle; returns at the negedge where reset is released (cycle 0).
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        bus.car_farm = 1'b1;
        bus.car_left = 1'b1;
        model_reset();
        #1;
        chk("rst_lamps", int'({bus.HGS, bus.HGL, bus.HGR, bus.HY, bus.HR, bus.FG, bus.FY, bus.FR}), 8'hA1);
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_pends", int'({bus.farm_pend, bus.left_pend}), 0);
        exp_q.push_back(model_out());
        @(negedge clk);
        exp_q.push_back(model_out());
        @(negedge clk);
        bus.car_farm = 1'b0;
        bus.car_left = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        bit hold;
        bus.car_farm = 1'b0;
        bus.car_left = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Idle: highway green throughout.
        for (int k = 0; k < 100; k++) begin
            if (k == 50) chk("s1_lamps", int'({bus.HGS, bus.HGR, bus.FR, bus.FG}), 4'b1110);
            if (k == 99) chk("s1_phase", int'(bus.phase), 0);
            cyc_drive(0, 0);
        end

        // Single farm pulse at cycle 2.
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            if (k == 3)  chk("s2_pend3", int'(bus.farm_pend), 1);
            if (k == 7)  chk("s2_go7", int'(bus.phase), 0);
            if (k == 8)  chk("s2_yel8", int'(bus.phase), 2);
            if (k == 11) chk("s2_clr11", int'(bus.phase), 3);
            if (k == 12) chk("s2_fg12", int'({bus.FG, bus.farm_pend}), 2'b10);
            if (k == 16) chk("s2_fg16", int'(bus.FG), 1);
            if (k == 17) chk("s2_fy17", int'(bus.phase), 5);
            if (k == 20) chk("s2_clr20", int'(bus.phase), 6);
            if (k == 21) chk("s2_go21", int'(bus.phase), 0);
            cyc_drive(k == 2, 0);
        end

        // Farm sensor held: max green, then a second farm cycle.
        apply_reset();
        for (int k = 0; k < 45; k++) begin
            if (k == 23) chk("s3_fg23", int'(bus.FG), 1);
            if (k == 24) chk("s3_fy24", int'(bus.phase), 5);
            if (k == 35) chk("s3_go35", int'(bus.phase), 0);
            if (k == 36) chk("s3_yel36", int'(bus.phase), 2);
            cyc_drive(k >= 2 && k <= 40, 0);
        end

        // Both requests together: farm first, then left arrow.
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            if (k == 21) chk("s4_go21", int'(bus.phase), 0);
            if (k == 28) chk("s4_go28", int'(bus.phase), 0);
            if (k == 29) chk("s4_left29", int'({bus.HGL, bus.HGR, bus.HGS}), 3'b110);
            if (k == 32) chk("s4_left32", int'(bus.HGL), 1);
            if (k == 33) chk("s4_go33", int'(bus.phase), 0);
            cyc_drive(k == 1, k == 1);
        end

        // Left pulse after min green; second pulse during the arrow is dropped.
        apply_reset();
        for (int k = 0; k < 25; k++) begin
            if (k == 12) chk("s5_left12", int'(bus.phase), 1);
            if (k == 14) chk("s5_lpend14", int'(bus.left_pend), 0);
            if (k == 16) chk("s5_go16", int'({bus.phase, bus.HY}), 0);
            cyc_drive(0, k == 10 || k == 13);
        end

        // Reset in the middle of farm green with a left request latched.
        apply_reset();
        for (int k = 0; k < 15; k++) cyc_drive(k == 1, k == 13);
        chk("s6_pre", int'({bus.FG, bus.left_pend}), 2'b11);
        apply_reset();
        for (int k = 0; k < 100; k++) cyc_drive(0, 0);
        chk("s6_idle", int'(bus.phase), 0);

        // Random traffic with occasional resets.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            if ($urandom_range(0, 399) == 0) apply_reset();
            else cyc_drive(hold ^ ($urandom_range(0, 19) == 0), $urandom_range(0, 24) == 0);
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
